// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC and fetches one word at a time over req/gnt/rvalid.
// It presents one instruction to decode, applies taken-branch redirects and absorbs one stalled response in a skid slot.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  PCsrc,
    input  logic [ADDR_WIDTH-1:0] ImmOp,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic                  skid_valid;
    logic                  discard;

    logic                  consume;
    logic                  redirect;
    logic                  grant;
    logic                  resp_in;
    logic                  resp;
    logic                  out_load;
    logic                  skid_load;
    logic                  skid_drain;
    logic [ADDR_WIDTH-1:0] target;

    assign imem_req   = (state == REQ) && !skid_valid;
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;

    assign consume    = instr_valid && !stall;
    assign redirect   = consume && PCsrc;
    assign target     = (pc + ImmOp) & ~ADDR_WIDTH'(3);

    assign resp_in    = (state == WAIT) && imem_rvalid;
    assign resp       = resp_in && !discard && !redirect;

    // A fresh response may only bypass to the output when nothing older sits in the skid.
    assign skid_drain = consume && skid_valid;
    assign out_load   = resp && (!instr_valid || (consume && !skid_valid));
    assign skid_load  = resp && !out_load;

    // NOTE: every register here uses non-blocking assignments so all decisions see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            acc_addr    <= RESET_PC;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= RESET_PC;
            discard     <= 1'b0;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (grant) begin
                        state    <= WAIT;
                        acc_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) state <= REQ;
                end
                default: state <= IDLE;
            endcase

            if (resp_in && discard) discard <= 1'b0;

            if (redirect) begin
                fetch_pc    <= target;
                skid_valid  <= 1'b0;
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
                // The in-flight wrong-path response must be dropped when it returns.
                if (grant || ((state == WAIT) && !imem_rvalid)) discard <= 1'b1;
            end else begin
                if (resp) fetch_pc <= acc_addr + ADDR_WIDTH'(4);

                if (out_load) begin
                    instr       <= imem_rdata;
                    pc          <= acc_addr;
                    instr_valid <= 1'b1;
                end else if (skid_drain) begin
                    instr <= skid_instr;
                    pc    <= skid_pc;
                end else if (consume) begin
                    instr_valid <= 1'b0;
                    instr       <= NOP_INSTR;
                end

                if (skid_load) begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= acc_addr;
                end else if (skid_drain) begin
                    skid_valid <= 1'b0;
                end
            end
        end
    end

endmodule
